// File: rtl/ttl_adder_nibble_seq_pkg.sv
// ttl_adder_nibble_seq_pkg: shared state encoding, slice width and index-width helper
package ttl_adder_nibble_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ttl_74283_nodly.sv
// ttl_74283_nodly: zero-delay model of a 74283 fast-carry adder slice
module ttl_74283_nodly #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);
  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
endmodule

// File: rtl/ttl_adder_nibble_seq.sv
// ttl_adder_nibble_seq: nibble-serial add/subtract sequencer over one 4-bit slice
// Optional zero/overflow flag outputs are enabled by defining ADDSEQ_FLAGS_EN.
module ttl_adder_nibble_seq
  import ttl_adder_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 sub,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out
`ifdef ADDSEQ_FLAGS_EN
  ,
  output logic                 zero_flag,
  output logic                 ovf_flag
`endif
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic sub_q, sub_d, c_q, c_d, co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic s_c, accept, run, last;
  assign accept    = (state_q == IDLE) && in_valid;
  assign run       = (state_q == RUN);
  assign last      = (idx_q == LAST);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = co_q;
  assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
  ttl_74283_nodly #(.WIDTH(NIBBLE_W)) u_slice (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .c_i  (c_q),
    .sum_o(s_nib),
    .c_o  (s_c)
  );
  always_comb begin
    result_d = result_q;
    if (run) result_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_nib;
    state_d = accept ? RUN :
              (run && last) ? DONE :
              ((state_q == DONE) && out_ready) ? IDLE : state_q;
    a_d   = accept ? op_a : a_q;
    b_d   = accept ? op_b : b_q;
    sub_d = accept ? sub : sub_q;
    // subtraction is A + ~B + ~cin, so the carry register starts inverted
    c_d   = accept ? (cin ^ sub) : run ? s_c : c_q;
    idx_d = accept ? '0 : (run && !last) ? idx_q + 1'b1 : idx_q;
    co_d  = (run && last) ? s_c : co_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      co_q     <= co_d;
    end
  end
`ifdef ADDSEQ_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
  always_comb begin
    zero_d = (run && last) ? (result_d == '0) : zero_q;
    // carry into the MSB is recovered from the top sum bit and its two addends
    ovf_d  = (run && last) ? (a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ s_nib[NIBBLE_W-1] ^ s_c) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end
`endif
endmodule

// File: tb/tb_ttl_adder_nibble_seq.sv
// tb_ttl_adder_nibble_seq: vectors, random ops vs arithmetic model, backpressure/reset/1-nibble cases
module tb_ttl_adder_nibble_seq;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic in_valid, in_ready, sub, cin, out_valid, out_ready, carry_out;
  logic [15:0] op_a, op_b, result;
  logic v1, r1, s1, c1, ov1, ordy1, co1;
  logic [3:0] a1, b1, res1;
`ifdef ADDSEQ_FLAGS_EN
  logic zf, vf, zf1, vf1;
`endif

  ttl_adder_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out)
`ifdef ADDSEQ_FLAGS_EN
    , .zero_flag(zf), .ovf_flag(vf)
`endif
  );

  ttl_adder_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
    .op_a(a1), .op_b(b1), .sub(s1), .cin(c1), .out_valid(ov1),
    .out_ready(ordy1), .result(res1), .carry_out(co1)
`ifdef ADDSEQ_FLAGS_EN
    , .zero_flag(zf1), .ovf_flag(vf1)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic s, c;
    logic [15:0] r;
    logic co, z, v;
  } vec_t;
  vec_t tbl[7];

  function automatic void model(input logic [15:0] a, b, input logic s, c,
                                output logic [15:0] r, output logic co, z, v);
    int ua, ub, ur, sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    ur = s ? ua - ub - int'(c) : ua + ub + int'(c);
    sr = s ? sa - sb - int'(c) : sa + sb + int'(c);
    r  = ur[15:0];
    co = s ? (ua >= ub + int'(c)) : (ur > 65535);
    z  = (r == 16'h0);
    v  = (sr > 32767) || (sr < -32768);
  endfunction

  task automatic wait_ov(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 100) break;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, b, input logic s, c,
                        output logic [15:0] r, output logic co, z, v, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_ov(lat);
    r = result; co = carry_out; z = 1'b0; v = 1'b0;
`ifdef ADDSEQ_FLAGS_EN
    z = zf; v = vf;
`endif
    @(posedge clk);
  endtask

  task automatic check_op(input string nm, input logic [15:0] a, b, input logic s, c,
                          input logic [15:0] er, input logic eco, ez, ev);
    logic [15:0] r;
    logic co, z, v;
    int lat;
    run_op(a, b, s, c, r, co, z, v, lat);
    chk({nm, "_res"}, 32'(r), 32'(er));
    chk({nm, "_co"}, 32'(co), 32'(eco));
    chk({nm, "_lat"}, 32'(lat), 32'd4);
`ifdef ADDSEQ_FLAGS_EN
    chk({nm, "_zf"}, 32'(z), 32'(ez));
    chk({nm, "_vf"}, 32'(v), 32'(ev));
`else
    if (z !== 1'b0 || v !== 1'b0 || ez === 1'bx || ev === 1'bx) chk({nm, "_flagstub"}, 32'(z), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] a, b, er;
    logic s, c, eco, ez, ev;
    int lat, cnt;
    tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    in_valid = 0; op_a = 0; op_b = 0; sub = 0; cin = 0; out_ready = 1;
    v1 = 0; a1 = 0; b1 = 0; s1 = 0; c1 = 0; ordy1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c,
               tbl[i].r, tbl[i].co, tbl[i].z, tbl[i].v);

    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      s = 1'($urandom); c = 1'($urandom);
      model(a, b, s, c, er, eco, ez, ev);
      check_op($sformatf("rnd%0d", i), a, b, s, c, er, eco, ez, ev);
    end

    // backpressure: result held, new request ignored until drained
    @(negedge clk);
    op_a = 16'h0102; op_b = 16'h0304; sub = 0; cin = 0; in_valid = 1; out_ready = 0;
    @(posedge clk);
    #1 op_a = 16'h1111; op_b = 16'h2222;
    wait_ov(lat);
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h0406);
      chk("bp_carry", 32'(carry_out), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_drain_idle", 32'(in_ready), 32'd1);
    chk("bp_drain_ov", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 0;
    wait_ov(lat);
    chk("bp_next_lat", 32'(lat), 32'd4);
    chk("bp_next_result", 32'(result), 32'h3333);
    @(posedge clk);

    // reset on the second RUN cycle aborts the operation
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; in_valid = 1; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ov", 32'(out_valid), 32'd0);
    reset = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_ov", 32'(cnt), 32'd0);
    model(16'h0001, 16'h0001, 1'b0, 1'b0, er, eco, ez, ev);
    check_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, er, eco, ez, ev);

    // single-nibble build
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h1; s1 = 0; c1 = 1; v1 = 1; ordy1 = 1;
    @(posedge clk);
    #1 v1 = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (ov1 || lat > 100) break;
      lat++;
    end
    chk("n1_lat", 32'(lat), 32'd1);
    chk("n1_result", 32'(res1), 32'h1);
    chk("n1_carry", 32'(co1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("n1_idle", 32'(r1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ttl_adder_nibble_seq.md
Name: ttl_adder_nibble_seq

Overview:
- Nibble-serial multi-precision add/subtract sequencer built around one 4-bit fast-carry adder slice.
- Accepts a NIBBLES×4-bit operand pair over a valid/ready handshake.
- Feeds the slice one nibble per clock, LSB first, and carries the slice's C_out forward in a register.
- Returns the full-width result and final carry over a second valid/ready handshake.
- Replaces cascaded adder chips in arcade datapaths (score/coordinate arithmetic) where one cycle per nibble is affordable.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (operand width = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- op_a  input  4*NIBBLES  operand A.
- op_b  input  4*NIBBLES  operand B.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin, computed as A + ~B + ~cin.
- cin  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  4*NIBBLES  sum/difference.
- carry_out  output  1  raw carry out of the top nibble (sub: 1 = no borrow).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- States: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result = 0; carry_out = 0; nibble index = 0; carry register = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch op_a, op_b, sub; carry register := cin XOR sub; index := 0; go to RUN.
  - No other input affects state.
- RUN:
  - in_ready = 0; out_valid = 0.
  - Each cycle the slice gets A nibble[index], B nibble[index] (XOR sub on each bit), and the carry register as C_in.
  - At the edge: result nibble[index] := slice Sum; carry register := slice C_out; index := index+1.
  - After the edge at index = NIBBLES-1: carry_out := slice C_out; go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid = 1; result and carry_out are held stable.
  - On out_valid & out_ready: go to IDLE.
  - in_ready stays 0 in DONE. There is no accept in the same cycle as output drain.
- Latency: the acceptance edge is edge 0. out_valid is first high after edge NIBBLES. Minimum throughput is one operation per NIBBLES+2 cycles.
- Arithmetic:
  - Width is exactly 4*NIBBLES. Overflow wraps modulo 2^(4*NIBBLES) and is signalled only through carry_out.
  - The operand registers are private. Changing op_a/op_b/sub/cin during RUN or DONE has no effect.
- NIBBLES = 1: RUN lasts one cycle, and the index never advances past 0.
- Reset mid-operation: the operation is aborted, all reset values apply on the next cycle, and no out_valid is produced for the aborted request.
- Reset wins over a simultaneous handshake.
- result keeps its last value after leaving DONE until the next operation overwrites it.

Optional Feature:
- Macro: ADDSEQ_FLAGS_EN.
- When defined, adds two outputs, both reset to 0 and valid/held under the same rules as result:
  - zero_flag  output  1  result == 0.
  - ovf_flag  output  1  signed overflow = carry into MSB XOR carry_out of the top nibble.
- ovf_flag requires the top-nibble MSB carry. This is computed locally as A[msb]^B'[msb]^Sum[msb]; the slice is not modified.
- When not defined, these ports and logic are absent and the ports list above is exact.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE) with its encoding.
  - NIBBLE_W = 4.
  - index width function clog2(NIBBLES) with minimum 1.
- One sub-module: ttl_74283_nodly instance with WIDTH = NIBBLE_W, used as the nibble slice. No new sub-module is needed.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FCD, cin=0 -> result 0x2201, carry_out 0; out_valid first high 4 edges after the acceptance edge.
- Add 0xFFFF + 0x0001, cin=0 -> result 0x0000, carry_out 1 (full ripple across all nibbles); with ADDSEQ_FLAGS_EN, zero_flag 1, ovf_flag 0.
- sub=1: 0x1000 - 0x0001, cin=0 -> 0x0FFF, carry_out 1; 0x0000 - 0x0001 -> 0xFFFF, carry_out 0; 0x8000 - 0x0001 -> 0x7FFF, ovf_flag 1 (flags build).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, result, carry_out constant; in_ready 0; a new in_valid is ignored. Release -> IDLE, then the new request is accepted.
- Reset asserted on the second RUN cycle -> next cycle IDLE, in_ready 1, result 0, no out_valid. A following 0x0001+0x0001 gives 0x0002.
- NIBBLES=1 build: 0xF + 0x1, cin=1 -> result 0x1, carry_out 1, out_valid after 1 edge.
